// File: rtl/reg_arb_pkg.sv
// Shared types and default sizing for the round-robin register write arbiter.
// Imported by the interface, bank and arbiter top.
package reg_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_DATA_W   = 8;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side bundle: per-requester write request, lock, address, data
// and the one-hot grant pulse returned by the arbiter.
interface reg_write_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W
);

  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0]             lock;
  logic [NUM_REQ-1:0][AW-1:0]     wr_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] wr_data;
  logic [NUM_REQ-1:0]             gnt;

  modport master (
    output req,
    output lock,
    output wr_addr,
    output wr_data,
    input  gnt
  );

  modport slave (
    input  req,
    input  lock,
    input  wr_addr,
    input  wr_data,
    output gnt
  );

endinterface

// File: rtl/reg_write_arbiter_en_reg_bank.sv
// Bank of enable-gated registers with a shared data input and a
// synchronous clear that overrides every enable.
module en_reg_bank
  import reg_arb_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr_i,
  input  logic [NUM_REGS-1:0]              en_i,
  input  logic [DATA_W-1:0]                d_i,
  output logic [NUM_REGS-1:0][DATA_W-1:0]  q_o
);

  logic [NUM_REGS-1:0][DATA_W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (clr_i) begin
      q_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (en_i[i]) q_q[i] <= d_i;
      end
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter with locked bursts in front of a shared
// enable-register bank; one registered write stage between grant and bank.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W,
  localparam int AW      = $clog2(NUM_REGS),
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clr,
  reg_write_arbiter_if.slave              bus,
  output logic [NUM_REGS-1:0][DATA_W-1:0] q,
  output logic [IW-1:0]                   owner,
  output logic                            locked
);

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               we_q, we_d;
  logic [AW-1:0]      waddr_q, waddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  logic [NUM_REQ-1:0] own_m;
  logic [NUM_REQ-1:0] elig;
  logic [IW:0]        pick;
  logic               win_vld;
  logic [IW-1:0]      win;

  // First eligible requester at or above p, wrapping; {valid, index}.
  function automatic logic [IW:0] rr_pick(
    input logic [NUM_REQ-1:0] e,
    input logic [IW-1:0]      p
  );
    logic [IW:0]   r;
    logic [IW-1:0] c;
    r = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      c = IW'((int'(p) + i) % NUM_REQ);
      if (e[c]) r = {1'b1, c};
    end
    return r;
  endfunction

  always_comb begin
    own_m          = '0;
    own_m[owner_q] = 1'b1;
    // A requester granted last edge sits out one cycle.
    elig = bus.req & ~gnt_q;
    if (state_q == ARB_LOCKED) elig = elig & own_m;
    pick    = rr_pick(elig, ptr_q);
    win_vld = pick[IW];
    win     = pick[IW-1:0];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = '0;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (win_vld) begin
      gnt_d[win] = 1'b1;
      we_d       = ~clr;
      waddr_d    = bus.wr_addr[win];
      wdata_d    = bus.wr_data[win];
      ptr_d      = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      if (bus.lock[win]) begin
        state_d = ARB_LOCKED;
        owner_d = win;
      end else begin
        state_d = ARB_IDLE;
      end
    end else if (state_q == ARB_LOCKED &&
                 !bus.req[owner_q] && !bus.lock[owner_q]) begin
      state_d = ARB_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  logic [NUM_REGS-1:0] bank_en;

  assign bank_en = we_q ? (NUM_REGS'(1) << waddr_q) : '0;

  en_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) u_bank (
    .clk   (clk),
    .rst_n (reset),
    .clr_i (clr),
    .en_i  (bank_en),
    .d_i   (wdata_q),
    .q_o   (q)
  );

  assign bus.gnt = gnt_q;
  assign owner   = owner_q;
  assign locked  = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: vector table for round-robin,
// single-requester and clear cases, hand sequences for bursts and reset.
module tb_reg_write_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic clr;
  logic [7:0][7:0] q;
  logic [1:0] owner;
  logic locked;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  reg_write_arbiter_if #(.NUM_REQ(4), .NUM_REGS(8), .DATA_W(8)) bus ();

  reg_write_arbiter #(
    .NUM_REQ  (4),
    .NUM_REGS (8),
    .DATA_W   (8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .bus    (bus),
    .q      (q),
    .owner  (owner),
    .locked (locked)
  );

  typedef struct {
    string           name;
    logic [3:0]      req;
    logic [3:0]      lock;
    logic            clr;
    logic [3:0][2:0] addr;
    logic [3:0][7:0] data;
    logic [3:0]      eg;
    logic            el;
    int              qi;
    logic [7:0]      eq;
  } vec_t;

  localparam logic [3:0][2:0] A_RR = {3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [3:0][7:0] D_RR = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  localparam logic [3:0][2:0] A_S  = {3'd0, 3'd0, 3'd5, 3'd0};
  localparam logic [3:0][7:0] D_S  = {8'h00, 8'h00, 8'h55, 8'h00};
  localparam logic [3:0][2:0] A_C  = {3'd7, 3'd0, 3'd0, 3'd0};
  localparam logic [3:0][7:0] D_C  = {8'hFF, 8'h00, 8'h00, 8'h00};

  vec_t v[12];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    v[0]  = '{"rr0",   4'hF, 4'h0, 1'b0, A_RR, D_RR, 4'b0001, 1'b0, 0, 8'h00};
    v[1]  = '{"rr1",   4'hF, 4'h0, 1'b0, A_RR, D_RR, 4'b0010, 1'b0, 0, 8'hA0};
    v[2]  = '{"rr2",   4'hF, 4'h0, 1'b0, A_RR, D_RR, 4'b0100, 1'b0, 1, 8'hA1};
    v[3]  = '{"rr3",   4'hF, 4'h0, 1'b0, A_RR, D_RR, 4'b1000, 1'b0, 2, 8'hA2};
    v[4]  = '{"rrwrap",4'hF, 4'h0, 1'b0, A_RR, D_RR, 4'b0001, 1'b0, 3, 8'hA3};
    v[5]  = '{"s1",    4'h2, 4'h0, 1'b0, A_S,  D_S,  4'b0010, 1'b0, 0, 8'hA0};
    v[6]  = '{"sgap",  4'h2, 4'h0, 1'b0, A_S,  D_S,  4'b0000, 1'b0, 5, 8'h55};
    v[7]  = '{"s2",    4'h2, 4'h0, 1'b0, A_S,  D_S,  4'b0010, 1'b0, 5, 8'h55};
    v[8]  = '{"sgap2", 4'h2, 4'h0, 1'b0, A_S,  D_S,  4'b0000, 1'b0, 2, 8'hA2};
    v[9]  = '{"clr",   4'h8, 4'h0, 1'b1, A_C,  D_C,  4'b1000, 1'b0, 5, 8'h00};
    v[10] = '{"clrw",  4'h0, 4'h0, 1'b0, A_C,  D_C,  4'b0000, 1'b0, 7, 8'h00};
    v[11] = '{"idle",  4'h0, 4'h0, 1'b0, A_C,  D_C,  4'b0000, 1'b0, 3, 8'h00};

    reset       = 1'b0;
    clr         = 1'b0;
    bus.req     = 4'hF;
    bus.lock    = 4'h0;
    bus.wr_addr = A_RR;
    bus.wr_data = D_RR;
    tick();
    tick();
    chk("rst_gnt", 64'(bus.gnt), 64'h0);
    chk("rst_q", 64'(q), 64'h0);
    chk("rst_locked", 64'(locked), 64'h0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      bus.req     = v[i].req;
      bus.lock    = v[i].lock;
      clr         = v[i].clr;
      bus.wr_addr = v[i].addr;
      bus.wr_data = v[i].data;
      tick();
      chk({v[i].name, "_gnt"}, 64'(bus.gnt), 64'(v[i].eg));
      chk({v[i].name, "_lck"}, 64'(locked), 64'(v[i].el));
      chk({v[i].name, "_q"}, 64'(q[v[i].qi]), 64'(v[i].eq));
    end

    // Locked burst by requester 2 while requester 0 waits.
    bus.req        = 4'b0100;
    bus.lock       = 4'b0100;
    bus.wr_addr    = {3'd0, 3'd3, 3'd0, 3'd0};
    bus.wr_data    = {8'h00, 8'h11, 8'h00, 8'h0C};
    tick();
    chk("b1_gnt", 64'(bus.gnt), 64'b0100);
    chk("b1_lck", 64'(locked), 64'h1);
    chk("b1_own", 64'(owner), 64'd2);
    bus.req        = 4'b0101;
    bus.wr_data[2] = 8'h22;
    tick();
    chk("b2_gnt", 64'(bus.gnt), 64'h0);
    chk("b2_lck", 64'(locked), 64'h1);
    chk("b2_q3", 64'(q[3]), 64'h11);
    tick();
    chk("b3_gnt", 64'(bus.gnt), 64'b0100);
    chk("b3_lck", 64'(locked), 64'h1);
    bus.lock       = 4'b0000;
    bus.wr_data[2] = 8'h33;
    tick();
    chk("b4_gnt", 64'(bus.gnt), 64'h0);
    chk("b4_lck", 64'(locked), 64'h1);
    chk("b4_q3", 64'(q[3]), 64'h22);
    tick();
    chk("b5_gnt", 64'(bus.gnt), 64'b0100);
    chk("b5_lck", 64'(locked), 64'h0);
    bus.req = 4'b0001;
    tick();
    chk("b6_gnt", 64'(bus.gnt), 64'b0001);
    chk("b6_q3", 64'(q[3]), 64'h33);
    bus.req = 4'b0000;
    tick();
    chk("b7_gnt", 64'(bus.gnt), 64'h0);
    chk("b7_q0", 64'(q[0]), 64'h0C);

    // Async reset between edges while locked.
    bus.req        = 4'b0100;
    bus.lock       = 4'b0100;
    bus.wr_data[2] = 8'h44;
    tick();
    chk("r1_lck", 64'(locked), 64'h1);
    chk("r1_gnt", 64'(bus.gnt), 64'b0100);
    #2 reset = 1'b0;
    #1;
    chk("r2_lck", 64'(locked), 64'h0);
    chk("r2_gnt", 64'(bus.gnt), 64'h0);
    chk("r2_q", 64'(q), 64'h0);
    chk("r2_own", 64'(owner), 64'h0);
    bus.req  = 4'b0000;
    bus.lock = 4'b0000;
    tick();
    reset   = 1'b1;
    bus.req = 4'b0001;
    tick();
    chk("r3_gnt", 64'(bus.gnt), 64'b0001);
    chk("r3_lck", 64'(locked), 64'h0);
    bus.req = 4'b0000;
    tick();
    chk("r4_q0", 64'(q[0]), 64'h0C);
    chk("r4_q3", 64'(q[3]), 64'h00);

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule
